handshake_cmpi_arbiter: RTL and testbench

HANDSHAKE_CMPI_ARBITER -- requirements
Module: handshake_cmpi_arbiter

---
 rtl/handshake_cmpi_arbiter.sv | 97 +++++++++
 tb/tb_handshake_cmpi_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_cmpi_arbiter.sv
// rtl/handshake_cmpi_arbiter.sv - round-robin arbiter sharing one signed less-than comparator between two requesters
// Optional conflict counter: define CMPI_ARB_CONFLICT_CNT_EN.
module handshake_cmpi_arbiter #(
    parameter int DATA_TYPE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_TYPE-1:0] lhs0,
    input  logic [DATA_TYPE-1:0] rhs0,
    input  logic                 lhs0_valid,
    input  logic                 rhs0_valid,
    input  logic [DATA_TYPE-1:0] lhs1,
    input  logic [DATA_TYPE-1:0] rhs1,
    input  logic                 lhs1_valid,
    input  logic                 rhs1_valid,
    output logic                 lhs0_ready,
    output logic                 rhs0_ready,
    output logic                 lhs1_ready,
    output logic                 rhs1_ready,
`ifdef CMPI_ARB_CONFLICT_CNT_EN
    output logic [15:0]          conflict_count,
`endif
    output logic                 result0,
    output logic                 result1,
    output logic                 result0_valid,
    output logic                 result1_valid,
    input  logic                 result0_ready,
    input  logic                 result1_ready
);

    logic                 elig0, elig1;
    logic                 grant0, grant1;
    logic                 last_grant1;
    logic [DATA_TYPE-1:0] cmp_a, cmp_b;
    logic                 cmp_lt;

    // A slot can accept a new result if it is empty or being drained this cycle.
    always_comb begin
        elig0  = lhs0_valid && rhs0_valid && (!result0_valid || result0_ready);
        elig1  = lhs1_valid && rhs1_valid && (!result1_valid || result1_ready);
        grant0 = elig0 && (!elig1 || last_grant1);
        grant1 = elig1 && !grant0;
    end

    assign lhs0_ready = grant0 && rst;
    assign rhs0_ready = grant0 && rst;
    assign lhs1_ready = grant1 && rst;
    assign rhs1_ready = grant1 && rst;

    assign cmp_a  = grant1 ? lhs1 : lhs0;
    assign cmp_b  = grant1 ? rhs1 : rhs0;
    assign cmp_lt = $signed(cmp_a) < $signed(cmp_b);

    // Reset value 1 makes requester 0 win the first conflict.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant1 <= 1'b1;
        end else if (grant0 || grant1) begin
            last_grant1 <= grant1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result0       <= 1'b0;
            result0_valid <= 1'b0;
        end else if (grant0) begin
            result0       <= cmp_lt;
            result0_valid <= 1'b1;
        end else if (result0_ready) begin
            result0_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result1       <= 1'b0;
            result1_valid <= 1'b0;
        end else if (grant1) begin
            result1       <= cmp_lt;
            result1_valid <= 1'b1;
        end else if (result1_ready) begin
            result1_valid <= 1'b0;
        end
    end

`ifdef CMPI_ARB_CONFLICT_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_count <= 16'h0000;
        end else if (elig0 && elig1 && (conflict_count != 16'hFFFF)) begin
            conflict_count <= conflict_count + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_handshake_cmpi_arbiter.sv
// tb/tb_handshake_cmpi_arbiter.sv - directed scoreboard bench for handshake_cmpi_arbiter
module tb_handshake_cmpi_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] lhs0, rhs0, lhs1, rhs1;
    logic        lhs0_valid, rhs0_valid, lhs1_valid, rhs1_valid;
    logic        lhs0_ready, rhs0_ready, lhs1_ready, rhs1_ready;
    logic        result0, result1, result0_valid, result1_valid;
    logic        result0_ready, result1_ready;
    logic        b_lhs0_ready, b_rhs0_ready, b_lhs1_ready, b_rhs1_ready;
    logic        b_result0, b_result1, b_result0_valid, b_result1_valid;
`ifdef CMPI_ARB_CONFLICT_CNT_EN
    logic [15:0] conflict_count, b_conflict_count;
`endif

    int tests = 0;
    int fails = 0;

    logic mv0, mv1, mlast1;
    logic [15:0] mcc;
    bit q0[$];
    bit q1[$];

    always #5 clk = ~clk;

    handshake_cmpi_arbiter #(.DATA_TYPE(32)) dut (
        .clk(clk), .rst(rst),
        .lhs0(lhs0), .rhs0(rhs0), .lhs0_valid(lhs0_valid), .rhs0_valid(rhs0_valid),
        .lhs1(lhs1), .rhs1(rhs1), .lhs1_valid(lhs1_valid), .rhs1_valid(rhs1_valid),
        .lhs0_ready(lhs0_ready), .rhs0_ready(rhs0_ready),
        .lhs1_ready(lhs1_ready), .rhs1_ready(rhs1_ready),
`ifdef CMPI_ARB_CONFLICT_CNT_EN
        .conflict_count(conflict_count),
`endif
        .result0(result0), .result1(result1),
        .result0_valid(result0_valid), .result1_valid(result1_valid),
        .result0_ready(result0_ready), .result1_ready(result1_ready)
    );

    handshake_cmpi_arbiter #(.DATA_TYPE(8)) dut8 (
        .clk(clk), .rst(rst),
        .lhs0(lhs0[7:0]), .rhs0(rhs0[7:0]), .lhs0_valid(lhs0_valid), .rhs0_valid(rhs0_valid),
        .lhs1(lhs1[7:0]), .rhs1(rhs1[7:0]), .lhs1_valid(lhs1_valid), .rhs1_valid(rhs1_valid),
        .lhs0_ready(b_lhs0_ready), .rhs0_ready(b_rhs0_ready),
        .lhs1_ready(b_lhs1_ready), .rhs1_ready(b_rhs1_ready),
`ifdef CMPI_ARB_CONFLICT_CNT_EN
        .conflict_count(b_conflict_count),
`endif
        .result0(b_result0), .result1(b_result1),
        .result0_valid(b_result0_valid), .result1_valid(b_result1_valid),
        .result0_ready(result0_ready), .result1_ready(result1_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mv0 = 1'b0;
        mv1 = 1'b0;
        mlast1 = 1'b1;
        mcc = 16'h0000;
        q0.delete();
        q1.delete();
    endtask

    task automatic check_slot(input string tag, input logic mv, input logic rdy,
                              input logic obs_valid, input logic obs_res, inout bit q[$]);
        check({tag, "_valid"}, {31'd0, obs_valid}, {31'd0, mv});
        if (mv) begin
            if (q.size() == 0) begin
                check({tag, "_underflow"}, 32'd0, 32'd1);
            end else begin
                check({tag, "_data"}, {31'd0, obs_res}, {31'd0, q[0]});
                if (rdy) void'(q.pop_front());
            end
        end
    endtask

    // Inputs are set just after a rising edge; readies are checked at the falling edge.
    task automatic step(input string tag);
        logic e0, e1, g0, g1;
        e0 = lhs0_valid && rhs0_valid && (!mv0 || result0_ready);
        e1 = lhs1_valid && rhs1_valid && (!mv1 || result1_ready);
        g0 = e0 && (!e1 || mlast1);
        g1 = e1 && !g0;
        @(negedge clk);
        check({tag, ":lhs0_ready"}, {31'd0, lhs0_ready}, {31'd0, g0});
        check({tag, ":rhs0_ready"}, {31'd0, rhs0_ready}, {31'd0, g0});
        check({tag, ":lhs1_ready"}, {31'd0, lhs1_ready}, {31'd0, g1});
        check({tag, ":rhs1_ready"}, {31'd0, rhs1_ready}, {31'd0, g1});
        check_slot({tag, ":result0"}, mv0, result0_ready, result0_valid, result0, q0);
        check_slot({tag, ":result1"}, mv1, result1_ready, result1_valid, result1, q1);
`ifdef CMPI_ARB_CONFLICT_CNT_EN
        check({tag, ":conflict_count"}, {16'd0, conflict_count}, {16'd0, mcc});
        if (e0 && e1 && mcc != 16'hFFFF) mcc++;
`endif
        if (g0) q0.push_back($signed(lhs0) < $signed(rhs0));
        if (g1) q1.push_back($signed(lhs1) < $signed(rhs1));
        mv0 = g0 || (mv0 && !result0_ready);
        mv1 = g1 || (mv1 && !result1_ready);
        if (g0 || g1) mlast1 = g1;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0l, input logic v0r, input logic v1l, input logic v1r,
                         input logic r0, input logic r1);
        lhs0_valid = v0l; rhs0_valid = v0r;
        lhs1_valid = v1l; rhs1_valid = v1r;
        result0_ready = r0; result1_ready = r1;
    endtask

    initial begin
        rst = 1'b0;
        lhs0 = '0; rhs0 = '0; lhs1 = '0; rhs1 = '0;
        drive(1, 1, 1, 1, 1, 1);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst:lhs0_ready", {31'd0, lhs0_ready}, 32'd0);
        check("rst:lhs1_ready", {31'd0, lhs1_ready}, 32'd0);
        check("rst:result0_valid", {31'd0, result0_valid}, 32'd0);
        check("rst:result1_valid", {31'd0, result1_valid}, 32'd0);
        check("rst:result0", {31'd0, result0}, 32'd0);
        check("rst:result1", {31'd0, result1}, 32'd0);
`ifdef CMPI_ARB_CONFLICT_CNT_EN
        check("rst:conflict_count", {16'd0, conflict_count}, 32'd0);
`endif
        drive(0, 0, 0, 0, 1, 1);
        rst = 1'b1;
        step("idle");

        // Single requester, negative vs positive operand
        lhs0 = -32'sd5; rhs0 = 32'sd3;
        drive(1, 1, 0, 0, 1, 1);
        step("single0");
        drive(0, 0, 0, 0, 1, 1);
        step("single0_out");
        step("single0_idle");

        // Continuous conflict: alternating grants
        lhs0 = 32'd1; rhs0 = 32'd2; lhs1 = 32'd7; rhs1 = 32'd7;
        drive(1, 1, 1, 1, 1, 1);
        repeat (4) step("conflict");
        drive(0, 0, 0, 0, 1, 1);
        step("conflict_drain");
        step("conflict_idle");

        // Backpressure on slot 0 must not block requester 1
        lhs0 = 32'd9; rhs0 = 32'd4;
        drive(1, 1, 0, 0, 0, 1);
        step("bp_fill");
        lhs0 = -32'sd100; rhs0 = 32'sd100;
        drive(1, 1, 1, 1, 0, 1);
        for (int i = 0; i < 4; i++) begin
            lhs1 = i; rhs1 = 2;
            step("bp_hold");
        end
        drive(0, 0, 0, 0, 1, 1);
        step("bp_release");
        step("bp_idle");

        // Join: one operand valid never produces a ready
        lhs1 = -32'sd1; rhs1 = 32'sd0;
        drive(0, 0, 1, 0, 1, 1);
        repeat (3) step("join_partial");
        drive(0, 0, 1, 1, 1, 1);
        step("join_full");
        drive(0, 0, 0, 0, 1, 1);
        step("join_out");

        // Reset while slot 1 holds a result
        lhs1 = 32'd1; rhs1 = 32'd5;
        drive(0, 0, 1, 1, 1, 0);
        step("pre_rst");
        drive(1, 1, 1, 1, 0, 0);
        rst = 1'b0;
        #1;
        check("midrst:result1_valid", {31'd0, result1_valid}, 32'd0);
        check("midrst:result1", {31'd0, result1}, 32'd0);
        check("midrst:lhs0_ready", {31'd0, lhs0_ready}, 32'd0);
        check("midrst:rhs1_ready", {31'd0, rhs1_ready}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        lhs0 = 32'd3; rhs0 = 32'd3; lhs1 = -32'sd3; rhs1 = 32'sd3;
        drive(1, 1, 1, 1, 1, 1);
        step("post_rst_first");
        step("post_rst_second");
        drive(0, 0, 0, 0, 1, 1);
        step("post_rst_drain");
        step("post_rst_idle");

        // Sign boundaries: 32-bit extremes, and 8-bit extremes on the narrow instance
        lhs0 = 32'h8000_0000; rhs0 = 32'h7FFF_FFFF;
        drive(1, 1, 0, 0, 1, 1);
        step("min_vs_max32");
        lhs0 = 32'h0000_0080; rhs0 = 32'h0000_007F;
        step("w8_issue");
        check("w8:result0", {31'd0, b_result0}, 32'd1);
        check("w8:result0_valid", {31'd0, b_result0_valid}, 32'd1);
        drive(0, 0, 0, 0, 1, 1);
        step("w8_drain");
        step("w8_idle");

        for (int i = 0; i < 300; i++) begin
            lhs0 = $urandom; rhs0 = $urandom; lhs1 = $urandom; rhs1 = $urandom;
            if ($urandom_range(0, 3) == 0) rhs1 = lhs1;
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
            step("random");
        end
        drive(0, 0, 0, 0, 1, 1);
        step("random_drain");
        step("random_idle");

`ifdef CMPI_ARB_CONFLICT_CNT_EN
        drive(1, 1, 1, 1, 1, 1);
        repeat (65540) @(posedge clk);
        #1;
        check("sat:conflict_count", {16'd0, conflict_count}, 32'h0000_FFFF);
        @(posedge clk);
        #1;
        check("sat_hold:conflict_count", {16'd0, conflict_count}, 32'h0000_FFFF);
        drive(0, 0, 0, 0, 1, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
